microcode_sequencer: RTL and testbench

Fetch/execute engine that consumes the 19-bit microinstruction words produced by the team's 64-entry instruction ROM and runs them on the existing 8-bit AND/OR/XOR/NOT/prefix-adder datapath. It owns the program counter that drives the ROM address, a four-entry 8-bit register file, and an output strobe for results. It sits between the ROM, which is read combinationally, and any downstream consumer of computed bytes.

---
 rtl/microcode_sequencer.sv | 179 +++++++++++++++++
 tb/tb_microcode_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: fetch/execute engine for 19-bit microinstruction words
// read combinationally from a 64-entry ROM. It owns the PC, the IR, four
// 8-bit registers and a registered result strobe.
//
// Optional build macro: MICROSEQ_STEP_EN adds a `step` input. The FETCH->EXEC
// transition then happens only on edges where step=1, which allows
// single-stepping the program.
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | IR loads the ROM word at PC
// EXEC  | execute IR, write rd, advance PC (or stop on HALT)
// HALT  | program finished; start reruns the program from address 0
module microcode_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
`ifdef MICROSEQ_STEP_EN
    input  logic        step,
`endif
    output logic [5:0]  rom_address,
    input  logic [18:0] rom_databits,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    output logic [7:0]  out_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NOT   = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_ADDI  = 3'd5;
    localparam logic [2:0] OP_LOADI = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  pc;
    logic [18:0] ir;
    logic [7:0]  regs [4];

    logic        pc_clear;
    logic        ir_load;
    logic        exec_commit;
    logic        advance;
    logic [7:0]  alu_res;

    logic [2:0]  ir_op;
    logic [1:0]  ir_rd;
    logic [1:0]  ir_ra;
    logic [1:0]  ir_rb;
    logic        ir_out_en;
    logic        ir_cin;
    logic [7:0]  ir_imm;
    logic [7:0]  ra_val;
    logic [7:0]  rb_val;

    assign ir_op     = ir[18:16];
    assign ir_rd     = ir[15:14];
    assign ir_ra     = ir[13:12];
    assign ir_rb     = ir[11:10];
    assign ir_out_en = ir[9];
    assign ir_cin    = ir[8];
    assign ir_imm    = ir[7:0];
    assign ra_val    = regs[ir_ra];
    assign rb_val    = regs[ir_rb];

`ifdef MICROSEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign rom_address = pc;
    assign busy        = (state == S_FETCH) || (state == S_EXEC);
    assign done        = (state == S_HALT);

    // State register; reset always returns to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_nxt   = state;
        pc_clear    = 1'b0;
        ir_load     = 1'b0;
        exec_commit = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_clear  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                // IR reloads every FETCH cycle, so a held step still
                // picks up the word current at the advancing edge.
                ir_load = 1'b1;
                if (advance) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ir_op == OP_HALT) begin
                    state_nxt = S_HALT;
                end else begin
                    exec_commit = 1'b1;
                    state_nxt   = S_FETCH;
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_clear  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ALU: operands are the register values before this instruction's write.
    always_comb begin
        alu_res = 8'h00;
        case (ir_op)
            OP_AND:   alu_res = ra_val & rb_val;
            OP_OR:    alu_res = ra_val | rb_val;
            OP_XOR:   alu_res = ra_val ^ rb_val;
            OP_NOT:   alu_res = ~ra_val;
            OP_ADD:   alu_res = ra_val + rb_val + {7'b0, ir_cin};
            OP_ADDI:  alu_res = ra_val + ir_imm + {7'b0, ir_cin};
            OP_LOADI: alu_res = ir_imm;
            default:  alu_res = 8'h00;
        endcase
    end

    // PC, IR, register file and output strobe; reset wins over any commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc        <= 6'd0;
            ir        <= 19'd0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            out_valid <= 1'b0;
            if (pc_clear) begin
                pc <= 6'd0;
            end
            if (ir_load) begin
                ir <= rom_databits;
            end
            if (exec_commit) begin
                regs[ir_rd] <= alu_res;
                pc          <= pc + 6'd1;
                if (ir_out_en) begin
                    out_valid <= 1'b1;
                    out_data  <= alu_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed programs plus random
// ROM images, checked against an instruction-level reference model.
module tb_microcode_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  rom_address;
    logic [18:0] rom_databits;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [7:0]  out_data;
`ifdef MICROSEQ_STEP_EN
    logic        step;
`endif

    logic [18:0] rom [64];
    logic [7:0]  m_regs [4];
    logic [7:0]  m_out;
    int          n_tests = 0;
    int          n_fail  = 0;

    assign rom_databits = rom[rom_address];

    always #5 clock = ~clock;

    microcode_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
`ifdef MICROSEQ_STEP_EN
        .step         (step),
`endif
        .rom_address  (rom_address),
        .rom_databits (rom_databits),
        .busy         (busy),
        .done         (done),
        .out_valid    (out_valid),
        .out_data     (out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] enc(input int op, input int rd, input int ra, input int rb,
                                        input int oe, input int cin, input int imm);
        return {op[2:0], rd[1:0], ra[1:0], rb[1:0], oe[0], cin[0], imm[7:0]};
    endfunction

    // Result of one instruction from the instruction-set rules, in plain integers.
    function automatic int ref_result(input logic [18:0] w);
        int a, b, c, imm;
        a   = int'(m_regs[w[13:12]]);
        b   = int'(m_regs[w[11:10]]);
        c   = int'(w[8]);
        imm = int'(w[7:0]);
        case (w[18:16])
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return 255 - a;
            3'd4: return (a + b + c) % 256;
            3'd5: return (a + imm + c) % 256;
            3'd6: return imm;
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_out = 8'h00;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".addr"},  32'(rom_address), 32'd0);
        check({tag, ".busy"},  32'(busy),        32'd0);
        check({tag, ".done"},  32'(done),        32'd0);
        check({tag, ".valid"}, 32'(out_valid),   32'd0);
        check({tag, ".data"},  32'(out_data),    32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        start = 1'b0;
        model_clear();
        @(negedge clock);
        check("idle.busy", 32'(busy), 32'd0);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 64; i++) rom[i] = enc(7, 0, 0, 0, 0, 0, 0);
    endtask

    // Start the program and follow it instruction by instruction. The k-th
    // instruction is fetched in the cycle after edge N+1+2k and its effects
    // appear after edge N+2+2k. If it reaches instruction reset_idx still
    // running, reset is applied on that instruction's EXEC edge.
    task automatic run_program(input string tag, input int reset_idx);
        int          pc;
        bit          pend_valid;
        logic [18:0] w;
        int          r;
        pc         = 0;
        pend_valid = 1'b0;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
        for (int k = 0; k <= reset_idx; k++) begin
            w = rom[pc];
            check({tag, ".f_addr"},  32'(rom_address), 32'(pc));
            check({tag, ".f_busy"},  32'(busy),        32'd1);
            check({tag, ".f_done"},  32'(done),        32'd0);
            check({tag, ".f_valid"}, 32'(out_valid),   32'(pend_valid));
            check({tag, ".f_data"},  32'(out_data),    32'(m_out));
            start = 1'($urandom_range(0, 1));
            @(negedge clock);
            check({tag, ".e_addr"},  32'(rom_address), 32'(pc));
            check({tag, ".e_busy"},  32'(busy),        32'd1);
            check({tag, ".e_valid"}, 32'(out_valid),   32'd0);
            if (k == reset_idx) begin
                reset = 1'b1;
                start = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                start = 1'b0;
                check_zero({tag, ".rst"});
                model_clear();
                @(negedge clock);
                check_zero({tag, ".rst_idle"});
                return;
            end
            start = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (w[18:16] == 3'd7) begin
                start = 1'b0;
                check({tag, ".h_done"},  32'(done),        32'd1);
                check({tag, ".h_busy"},  32'(busy),        32'd0);
                check({tag, ".h_valid"}, 32'(out_valid),   32'd0);
                check({tag, ".h_addr"},  32'(rom_address), 32'(pc));
                @(negedge clock);
                check({tag, ".h2_done"}, 32'(done),        32'd1);
                check({tag, ".h2_addr"}, 32'(rom_address), 32'(pc));
                return;
            end
            r = ref_result(w);
            m_regs[w[15:14]] = 8'(r);
            if (w[9]) m_out = 8'(r);
            pend_valid = w[9];
            pc = (pc + 1) % 64;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
`ifdef MICROSEQ_STEP_EN
        step  = 1'b1;
`endif
        fill_halt();
        model_clear();
        @(negedge clock);
        do_reset();

        // AND of two loaded constants, HALT at address 3
        fill_halt();
        rom[0] = enc(6, 0, 0, 0, 0, 0, 'h3C);
        rom[1] = enc(6, 1, 0, 0, 0, 0, 'h0F);
        rom[2] = enc(0, 2, 0, 1, 1, 0, 0);
        run_program("and", 100);
        check("and.result", 32'(out_data), 32'h0C);

        // Rerun from HALT with registers retained
        run_program("and_rerun", 100);

        // Add wraparound and carry-in
        fill_halt();
        rom[0] = enc(6, 0, 0, 0, 0, 0, 'hFF);
        rom[1] = enc(5, 1, 0, 0, 1, 0, 'h01);
        rom[2] = enc(5, 1, 1, 0, 1, 1, 'h7F);
        rom[3] = enc(4, 3, 1, 1, 1, 0, 0);
        run_program("add", 100);

        // NOT then XOR
        fill_halt();
        rom[0] = enc(6, 0, 0, 0, 0, 0, 'hA5);
        rom[1] = enc(3, 1, 0, 3, 1, 0, 0);
        rom[2] = enc(2, 2, 1, 0, 1, 0, 0);
        run_program("notxor", 100);
        check("notxor.result", 32'(out_data), 32'hFF);

        // Reset during EXEC of address 2, then a clean rerun
        fill_halt();
        rom[0] = enc(6, 0, 0, 0, 0, 0, 'h3C);
        rom[1] = enc(6, 1, 0, 0, 0, 0, 'h0F);
        rom[2] = enc(0, 2, 0, 1, 1, 0, 0);
        run_program("rst_exec", 2);
        run_program("after_rst", 100);

        // 64 words without HALT: PC wraps and address 0 executes again
        for (int i = 0; i < 64; i++)
            rom[i] = enc($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                         $urandom_range(0, 255));
        run_program("wrap", 66);

        // Random programs with a HALT somewhere, each run twice
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 64; i++)
                rom[i] = enc($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                             $urandom_range(0, 255));
            rom[$urandom_range(1, 20)] = enc(7, $urandom_range(0, 3), 0, 0, 1, 0, 0);
            run_program("rand", 100);
            run_program("rand_rerun", 100);
        end

`ifdef MICROSEQ_STEP_EN
        // Held step stalls in FETCH; a one-cycle pulse advances one instruction
        fill_halt();
        rom[0] = enc(6, 2, 0, 0, 1, 0, 'h77);
        step  = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("step.hold_addr",  32'(rom_address), 32'd0);
            check("step.hold_busy",  32'(busy),        32'd1);
            check("step.hold_valid", 32'(out_valid),   32'd0);
            @(negedge clock);
        end
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        check("step.exec_addr", 32'(rom_address), 32'd0);
        @(negedge clock);
        check("step.valid", 32'(out_valid),   32'd1);
        check("step.data",  32'(out_data),    32'h77);
        check("step.addr",  32'(rom_address), 32'd1);
        m_regs[2] = 8'h77;
        m_out     = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("step.hold2_addr",  32'(rom_address), 32'd1);
            check("step.hold2_valid", 32'(out_valid),   32'd0);
        end
        step = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("step.done", 32'(done), 32'd1);
`endif

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
